// File: rtl/fifo_pkg.sv
// Shared constants for the fifo_sync read-side stream adapter.
// Latency: none (constants only).
// Backpressure: none (constants only).
package fifo_pkg;

   // Default data width of the attached fifo_sync.
   localparam int FIFO_DW    = 8;
   // Entries in the output skid buffer.
   localparam int SKID_DEPTH = 2;
   // Width needed to count 0..SKID_DEPTH.
   localparam int LVL_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order buffer; head entry is a register feeding the stream output directly.
// Latency: push visible at head one cycle later when empty; pop advances head at the clock edge.
// Backpressure: caller must not push when full without a same-cycle pop; such a push is dropped.
module stream_skid2
   import fifo_pkg::*;
#(
   parameter int DW = FIFO_DW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [DW-1:0]    push_data,
   input  logic             pop,
   output logic [DW-1:0]    head_data,
   output logic [LVL_W-1:0] level
);

   localparam logic [LVL_W-1:0] FULL = LVL_W'(SKID_DEPTH);

   logic [DW-1:0] tail_data;
   logic          pop_ok;

   // A pop against an empty buffer is meaningless and ignored.
   assign pop_ok = pop && (level != '0);

   // Shift-style storage: head always in head_data, second word in tail_data.
   // On simultaneous push+pop the head advances first, then the new word lands behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_data <= '0;
         tail_data <= '0;
         level     <= '0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (level == '0) begin
                  head_data <= push_data;
                  level     <= level + 1'b1;
               end else if (level != FULL) begin
                  tail_data <= push_data;
                  level     <= level + 1'b1;
               end
            end
            2'b01: begin
               head_data <= tail_data;
               level     <= level - 1'b1;
            end
            2'b11: begin
               if (level == FULL) begin
                  head_data <= tail_data;
                  tail_data <= push_data;
               end else begin
                  head_data <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Converts fifo_sync's pop/registered-read interface into a valid/ready stream with a delivered-word count.
// Latency: fifo_empty falling with an empty buffer gives m_valid two cycles after the pop.
// Backpressure: pops are only issued when the skid buffer can absorb the in-flight word; m_data/m_valid hold while stalled.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DW = FIFO_DW,
   parameter int CW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [DW-1:0]    fifo_r_data,
   output logic             fifo_r_en,
   output logic             m_valid,
   output logic [DW-1:0]    m_data,
   input  logic             m_ready,
   output logic [LVL_W-1:0] level,
   output logic [CW-1:0]    xfer_cnt
);

   logic             inflight;
   logic             pop;
   logic             rd_req;
   logic [LVL_W:0]   occupancy;
   logic [LVL_W:0]   room_limit;

   assign m_valid = (level != '0);
   assign pop     = m_valid && m_ready;

   // Words buffered plus the one returning from fifo_sync must stay below depth after this cycle's pop.
   assign occupancy  = {1'b0, level} + {{LVL_W{1'b0}}, inflight};
   assign room_limit = (LVL_W + 1)'(SKID_DEPTH) + {{LVL_W{1'b0}}, pop};
   assign rd_req     = !fifo_empty && (occupancy < room_limit);

   // Reset gates the pop request so fifo_sync is never popped while held in reset.
   assign fifo_r_en  = rst_n && rd_req;

   // A pop accepted now means fifo_r_data carries that word next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= rd_req;
      end
   end

   // Count every delivered word; wraps naturally at 2^CW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (pop) begin
         xfer_cnt <= xfer_cnt + CW'(1);
      end
   end

   stream_skid2 #(
      .DW (DW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_r_data),
      .pop       (pop),
      .head_data (m_data),
      .level     (level)
   );

endmodule
